// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity codes
// and the baud divider helper used by both TX and RX.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } uart_tx_state_t;

    // Clock cycles per bit, truncated.
    function automatic int baud_count(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Counter width able to hold 0..n-1, never zero.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Restartable bit-period tick generator: counts while enabled,
// ticks on the last cycle of each period, then wraps to zero.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_COUNT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = cnt_width(BAUD_COUNT);
    localparam logic [CW-1:0] LAST = CW'(BAUD_COUNT - 1);

    logic [CW-1:0] r_count;
    logic          w_tick;

    assign w_tick = enable && (r_count == LAST);
    assign tick   = w_tick;

    // Period counter; clear and wrap both restart the bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear || w_tick) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: valid/ready word input, serial frame out
// (start, data LSB first, optional parity, one or two stops).
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int WIDTH     = 8,
    parameter int PARITY    = PARITY_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             dataInValid,
    output logic             dataInReady,
    output logic             uartTx,
    output logic             txBusy,
    output logic             txDone
);

    localparam int         BAUD_COUNT = baud_count(CLK_FREQ, BAUD_RATE);
    localparam logic [3:0] LAST_BIT   = 4'(WIDTH - 1);
    localparam logic       LAST_STOP  = 1'(STOP_BITS - 1);
    localparam logic       ODD_PAR    = (PARITY == PARITY_ODD);
    localparam logic       HAS_PAR    = (PARITY != PARITY_NONE);

    uart_tx_state_t   r_state, w_state;
    logic [WIDTH-1:0] r_shift, w_shift;
    logic             r_parity, w_parity;
    logic [3:0]       r_bit_cnt, w_bit_cnt;
    logic             r_stop_cnt, w_stop_cnt;
    logic             r_tx, w_tx;
    logic             r_ready, w_ready;
    logic             w_done;
    logic             w_tick;
    logic             w_idle;

    assign w_idle = (r_state == TX_IDLE);

    uart_baud_gen #(
        .BAUD_COUNT(BAUD_COUNT)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (w_idle),
        .enable(!w_idle),
        .tick  (w_tick)
    );

    // State and datapath registers; line idles high in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= TX_IDLE;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_shift    <= w_shift;
            r_parity   <= w_parity;
            r_bit_cnt  <= w_bit_cnt;
            r_stop_cnt <= w_stop_cnt;
            r_tx       <= w_tx;
            r_ready    <= w_ready;
        end
    end

    // Frame sequencing: next state, next line level, done pulse.
    always_comb begin
        w_state    = r_state;
        w_shift    = r_shift;
        w_parity   = r_parity;
        w_bit_cnt  = r_bit_cnt;
        w_stop_cnt = r_stop_cnt;
        w_tx       = r_tx;
        w_ready    = r_ready;
        w_done     = 1'b0;
        unique case (r_state)
            TX_IDLE: begin
                w_ready = 1'b1;
                w_tx    = 1'b1;
                if (dataInValid && r_ready) begin
                    w_shift    = dataIn;
                    w_parity   = (^dataIn) ^ ODD_PAR;
                    w_ready    = 1'b0;
                    w_tx       = 1'b0;
                    w_bit_cnt  = '0;
                    w_stop_cnt = 1'b0;
                    w_state    = TX_START;
                end
            end
            TX_START: begin
                if (w_tick) begin
                    w_tx    = r_shift[0];
                    w_state = TX_DATA;
                end
            end
            TX_DATA: begin
                if (w_tick) begin
                    w_shift = {1'b0, r_shift[WIDTH-1:1]};
                    if (r_bit_cnt == LAST_BIT) begin
                        if (HAS_PAR) begin
                            w_tx    = r_parity;
                            w_state = TX_PARITY;
                        end else begin
                            w_tx    = 1'b1;
                            w_state = TX_STOP;
                        end
                    end else begin
                        w_bit_cnt = r_bit_cnt + 4'd1;
                        w_tx      = w_shift[0];
                    end
                end
            end
            TX_PARITY: begin
                if (w_tick) begin
                    w_tx    = 1'b1;
                    w_state = TX_STOP;
                end
            end
            TX_STOP: begin
                if (w_tick) begin
                    if (r_stop_cnt == LAST_STOP) begin
                        w_done  = 1'b1;
                        w_ready = 1'b1;
                        w_state = TX_IDLE;
                    end else begin
                        w_stop_cnt = 1'b1;
                    end
                end
            end
            default: begin
                w_state = TX_IDLE;
                w_tx    = 1'b1;
            end
        endcase
    end

    assign dataInReady = r_ready;
    assign uartTx      = r_tx;
    assign txBusy      = !w_idle;
    assign txDone      = w_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: four parity/stop configurations,
// a frame-level line model and directed literal checks.
module tb_uart_transmitter;

    localparam int B = 434;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [3:0] rst = 4'hF;
    logic [3:0] valid = 4'h0;
    logic [7:0] din [4];
    logic [3:0] rdy, tx, busy, done;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int par_of(input int i);
        return (i == 1) ? 1 : (i == 2) ? 2 : 0;
    endfunction

    function automatic int stp_of(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    function automatic int nbits_of(input int i);
        return 9 + ((par_of(i) != 0) ? 1 : 0) + stp_of(i);
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int P = (g == 1) ? 1 : (g == 2) ? 2 : 0;
        localparam int S = (g == 3) ? 2 : 1;

        uart_transmitter #(
            .CLK_FREQ (50_000_000),
            .BAUD_RATE(115200),
            .WIDTH    (8),
            .PARITY   (P),
            .STOP_BITS(S)
        ) u_dut (
            .clk        (clk),
            .reset      (rst[g]),
            .dataIn     (din[g]),
            .dataInValid(valid[g]),
            .dataInReady(rdy[g]),
            .uartTx     (tx[g]),
            .txBusy     (busy[g]),
            .txDone     (done[g])
        );

        // Model: line level is frame bit (t / B), t counted from accept.
        bit        m_busy = 1'b0;
        bit        m_rdy = 1'b0;
        int        m_t = 0;
        int        m_n = 0;
        bit [11:0] m_line = '1;
        logic [3:0] m_exp, m_act;

        initial forever begin
            @(posedge clk or posedge rst[g]);
            if (rst[g]) begin
                m_busy = 1'b0;
                m_rdy  = 1'b0;
                m_t    = 0;
            end else if (m_busy) begin
                if (m_t == m_n * B - 1) begin
                    m_busy = 1'b0;
                    m_rdy  = 1'b1;
                end else begin
                    m_t++;
                end
            end else if (m_rdy && valid[g]) begin
                m_line    = '1;
                m_line[0] = 1'b0;
                for (int j = 0; j < 8; j++) m_line[1+j] = din[g][j];
                if (P == 1) m_line[9] = ^din[g];
                if (P == 2) m_line[9] = ~(^din[g]);
                m_n    = 9 + ((P != 0) ? 1 : 0) + S;
                m_t    = 0;
                m_busy = 1'b1;
                m_rdy  = 1'b0;
            end else begin
                m_rdy = 1'b1;
            end
        end

        initial forever begin
            @(negedge clk);
            if (m_busy)
                m_exp = {m_line[m_t / B], 1'b0, 1'b1, (m_t == m_n * B - 1)};
            else
                m_exp = {1'b1, m_rdy, 2'b00};
            m_act = {tx[g], rdy[g], busy[g], done[g]};
            n_chk++;
            if (m_act !== m_exp) begin
                n_fail++;
                $display("FAIL model dut%0d cyc %0d {tx,rdy,busy,done} got %b expected %b",
                         g, cyc, m_act, m_exp);
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting on DUT", nm);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer a word; returns after the accepting edge with ta = first frame cycle.
    task automatic send(input int i, input logic [7:0] d, input bit hold,
                        output int ta);
        bit ok = 1'b0;
        din[i]   = d;
        valid[i] = 1'b1;
        for (int c = 0; c < 10000 && !ok; c++) begin
            @(negedge clk);
            if (rdy[i]) ok = 1'b1;
        end
        if (!ok) timeout("accept");
        @(posedge clk);
        #1;
        ta = cyc;
        if (!hold) valid[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input string nm);
        bit ok = 1'b0;
        for (int c = 0; c < 6000 && !ok; c++) begin
            @(negedge clk);
            if (done[i]) ok = 1'b1;
        end
        if (!ok) timeout(nm);
    endtask

    // Send one word, check every bit midpoint, frame length, stop-high cycles.
    task automatic frame_check(input int i, input logic [7:0] d,
                               input logic [11:0] seq, input int exp_len,
                               input int exp_stop, input string nm);
        int ta, n, k, hi, s0;
        bit got;
        n   = nbits_of(i);
        send(i, d, 1'b0, ta);
        s0  = ta + (n - stp_of(i)) * B;
        k   = 0;
        hi  = 0;
        got = 1'b0;
        for (int c = 0; c < 6000 && !got; c++) begin
            @(negedge clk);
            if (k < n && cyc == ta + B / 2 + k * B) begin
                check($sformatf("%s_bit%0d", nm, k), tx[i], seq[k]);
                k++;
            end
            if (cyc >= s0 && tx[i]) hi++;
            if (done[i]) begin
                got = 1'b1;
                check($sformatf("%s_len", nm), cyc + 1 - ta, exp_len);
            end
        end
        if (!got) timeout($sformatf("%s_done", nm));
        check($sformatf("%s_stop_high", nm), hi, exp_stop);
    endtask

    // Bench-side receiver: find start fall, sample data at midpoints.
    task automatic rx(input int i, output logic [7:0] b);
        int s;
        bit ok = 1'b0;
        b = '0;
        for (int c = 0; c < 10000 && !ok; c++) begin
            @(negedge clk);
            if (!tx[i]) ok = 1'b1;
        end
        if (!ok) timeout("rx_start");
        s = cyc;
        for (int k = 0; k < 8; k++) begin
            while (cyc < s + B / 2 + (k + 1) * B) @(negedge clk);
            b[k] = tx[i];
        end
        while (cyc < s + B / 2 + 9 * B) @(negedge clk);
    endtask

    initial begin
        int         ta, ta2, hi;
        bit         ok;
        logic [7:0] b;
        logic [7:0] lb [3];
        lb = '{8'h55, 8'hC3, 8'h00};
        for (int i = 0; i < 4; i++) din[i] = '0;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_tx%0d", i), tx[i], 1);
            check($sformatf("rst_rdy%0d", i), rdy[i], 0);
            check($sformatf("rst_busy%0d", i), busy[i], 0);
            check($sformatf("rst_done%0d", i), done[i], 0);
        end
        rst = 4'h0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            check($sformatf("rdy_rise%0d", i), rdy[i], 1);

        idle(3);
        frame_check(0, 8'h55, 12'b00_1010101010, 4340, 434, "f55");

        idle(5);
        send(0, 8'h00, 1'b1, ta);
        din[0] = 8'hFF;
        hi = 0;
        ok = 1'b0;
        for (int c = 0; c < 6000 && !ok; c++) begin
            @(negedge clk);
            if (tx[0]) hi++;
            if (rdy[0]) ok = 1'b1;
        end
        if (!ok) timeout("b2b_ready");
        @(posedge clk);
        #1;
        ta2 = cyc;
        valid[0] = 1'b0;
        check("b2b_gap_high", hi, 435);
        check("b2b_period", ta2 - ta, 4341);
        wait_done(0, "b2b_done");

        idle(5);
        send(0, 8'h0F, 1'b0, ta);
        while (cyc < ta + 4 * B + B / 2) @(negedge clk);
        #2 rst[0] = 1'b1;
        #1;
        check("midrst_tx", tx[0], 1);
        check("midrst_busy", busy[0], 0);
        check("midrst_done", done[0], 0);
        @(negedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        check("midrst_rdy_low", rdy[0], 0);
        @(posedge clk);
        #1;
        check("midrst_rdy_rise", rdy[0], 1);
        idle(2);
        frame_check(0, 8'h3C, 12'b00_1001111000, 4340, 434, "f3C");

        idle(5);
        fork
            begin
                for (int k = 0; k < 3; k++) send(0, lb[k], k < 2, ta);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    rx(0, b);
                    check($sformatf("loop%0d", k), b, lb[k]);
                end
            end
        join
        wait_done(0, "loop_done");

        idle(5);
        frame_check(1, 8'hA5, 12'b0_10101001010, 4774, 434, "fA5even");
        idle(5);
        frame_check(2, 8'h03, 12'b0_11000000110, 4774, 434, "f03odd");
        idle(5);
        frame_check(3, 8'h80, 12'b0_11100000000, 4774, 868, "f80stop2");
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #(80000 * 10);
        n_chk++;
        n_fail++;
        $display("FAIL watchdog: simulation exceeded cycle budget at cyc %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
